// File: rtl/stripes_weight_serializer.sv
// -----------------------------------------------------------------------------
// stripes_weight_serializer
//
// Transmit side of the bit-serial Stripes MAC interface. The block accepts one
// vector of VEC_LENGTH signed weights per valid/ready beat. It then issues that
// vector to the MAC one bit-column per cycle, starting with the LSB. The issue
// timing matches the MAC's two-stage pipeline: a psum register followed by the
// accumulator.
//
// Ports:
//   clk             clock
//   reset           synchronous, active-high
//   w_valid         weight beat valid
//   w_ready         serializer can accept a beat this cycle
//   w_in            VEC_LENGTH signed weights, lane j at [j*DATA_WIDTH +: DATA_WIDTH]
//   w_load          sideband captured with the beat; 1 = start tile from accum_prev
//   mac_en          MAC enable (registered)
//   mac_w_bit       current weight bit per lane (registered)
//   mac_column_idx  current bit index (registered)
//   mac_is_msb      current column is the sign bit (registered)
//   mac_load_accum  MAC selects accum_prev this cycle (registered)
//   done            one-cycle pulse, MAC result valid this cycle (registered)
//   busy            serializer not idle (registered)
// -----------------------------------------------------------------------------
module stripes_weight_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             w_valid,
  output logic                             w_ready,
  input  logic [VEC_LENGTH*DATA_WIDTH-1:0] w_in,
  input  logic                             w_load,
  output logic                             mac_en,
  output logic [VEC_LENGTH-1:0]            mac_w_bit,
  output logic [2:0]                       mac_column_idx,
  output logic                             mac_is_msb,
  output logic                             mac_load_accum,
  output logic                             done,
  output logic                             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [2:0] LAST_COL = 3'(DATA_WIDTH - 1);

  logic [1:0]                       state_r;
  logic [2:0]                       bit_cnt_r;
  logic [VEC_LENGTH*DATA_WIDTH-1:0] w_hold_r;
  logic                             load_hold_r;
  logic                             done_pend_r;

  logic                             accept_s;
  logic [1:0]                       state_next_s;
  logic [2:0]                       cnt_next_s;
  logic [VEC_LENGTH*DATA_WIDTH-1:0] hold_next_s;
  logic                             load_next_s;
  logic [VEC_LENGTH-1:0]            col_bits_s;

  // A beat can be taken when idle, during the drain cycle, or on the last
  // column so that consecutive tiles run without a bubble.
  assign w_ready = (state_r == IDLE) || (state_r == DRAIN) ||
                   ((state_r == SHIFT) && (bit_cnt_r == LAST_COL));

  assign accept_s = w_valid && w_ready;

  // Holding register only changes on an accepted beat.
  assign hold_next_s = accept_s ? w_in : w_hold_r;
  assign load_next_s = accept_s ? w_load : load_hold_r;

  // Next-state and bit counter logic.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = bit_cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = SHIFT;
          cnt_next_s   = 3'd0;
        end else begin
          state_next_s = IDLE;
          cnt_next_s   = 3'd0;
        end
      end
      SHIFT: begin
        if (bit_cnt_r == LAST_COL) begin
          if (accept_s) begin
            state_next_s = SHIFT;
            cnt_next_s   = 3'd0;
          end else begin
            state_next_s = DRAIN;
            cnt_next_s   = 3'd0;
          end
        end else begin
          state_next_s = SHIFT;
          cnt_next_s   = bit_cnt_r + 3'd1;
        end
      end
      DRAIN: begin
        if (accept_s) begin
          state_next_s = SHIFT;
          cnt_next_s   = 3'd0;
        end else begin
          state_next_s = IDLE;
          cnt_next_s   = 3'd0;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 3'd0;
      end
    endcase
  end

  // The outputs are registered, so the column is selected from the values the
  // holding register and counter will have next cycle. Shifting each lane avoids
  // a variable bit-select.
  for (genvar g = 0; g < VEC_LENGTH; g++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane_s;
    assign lane_s        = hold_next_s[g*DATA_WIDTH +: DATA_WIDTH] >> cnt_next_s;
    assign col_bits_s[g] = lane_s[0];
  end

  // State, holding register and registered MAC-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      bit_cnt_r      <= 3'd0;
      w_hold_r       <= {(VEC_LENGTH*DATA_WIDTH){1'b0}};
      load_hold_r    <= 1'b0;
      done_pend_r    <= 1'b0;
      mac_en         <= 1'b0;
      mac_w_bit      <= {VEC_LENGTH{1'b0}};
      mac_column_idx <= 3'd0;
      mac_is_msb     <= 1'b0;
      mac_load_accum <= 1'b0;
      done           <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      bit_cnt_r      <= cnt_next_s;
      w_hold_r       <= hold_next_s;
      load_hold_r    <= load_next_s;
      mac_en         <= (state_next_s != IDLE);
      busy           <= (state_next_s != IDLE);
      // DRAIN issues zero bits so the MAC's psum register flushes to 0.
      mac_w_bit      <= (state_next_s == SHIFT) ? col_bits_s : {VEC_LENGTH{1'b0}};
      mac_column_idx <= (state_next_s == SHIFT) ? cnt_next_s : 3'd0;
      mac_is_msb     <= (state_next_s == SHIFT) && (cnt_next_s == LAST_COL);
      // Column 0 is in the psum stage during the following cycle, which is when
      // the accumulator must select accum_prev.
      mac_load_accum <= (state_r == SHIFT) && (bit_cnt_r == 3'd0) && load_hold_r;
      // The last column needs psum and then accumulator, so the result is
      // valid two cycles after that column is issued.
      done_pend_r    <= (state_r == SHIFT) && (bit_cnt_r == LAST_COL);
      done           <= done_pend_r;
    end
  end

endmodule

// File: tb/tb_stripes_weight_serializer.sv
// -----------------------------------------------------------------------------
// Testbench for stripes_weight_serializer (DATA_WIDTH=8, VEC_LENGTH=16).
// Table-driven per-cycle vectors. Each row gives the inputs driven in that
// cycle and the outputs expected in that cycle. A hand-written sequence covers
// reset in the middle of a tile.
// -----------------------------------------------------------------------------
module tb_stripes_weight_serializer;

  localparam int DW = 8;
  localparam int VL = 16;

  logic             clk;
  logic             reset;
  logic             w_valid;
  logic             w_ready;
  logic [VL*DW-1:0] w_in;
  logic             w_load;
  logic             mac_en;
  logic [VL-1:0]    mac_w_bit;
  logic [2:0]       mac_column_idx;
  logic             mac_is_msb;
  logic             mac_load_accum;
  logic             done;
  logic             busy;

  stripes_weight_serializer #(.DATA_WIDTH(DW), .VEC_LENGTH(VL)) dut (
    .clk            (clk),
    .reset          (reset),
    .w_valid        (w_valid),
    .w_ready        (w_ready),
    .w_in           (w_in),
    .w_load         (w_load),
    .mac_en         (mac_en),
    .mac_w_bit      (mac_w_bit),
    .mac_column_idx (mac_column_idx),
    .mac_is_msb     (mac_is_msb),
    .mac_load_accum (mac_load_accum),
    .done           (done),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        load;
    logic [7:0]  l0;
    logic [7:0]  l1;
    logic        en;
    logic [15:0] bits;
    logic [2:0]  col;
    logic        msb;
    logic        ld;
    logic        dn;
    logic        bsy;
    logic        rdy;
  } row_t;

  row_t rows [0:31];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [24:0] observed();
    return {mac_en, mac_w_bit, mac_column_idx, mac_is_msb, mac_load_accum, done, busy, w_ready};
  endfunction

  task automatic clear_rows();
    for (int i = 0; i < 32; i++) begin
      rows[i].valid = 1'b0;
      rows[i].load  = 1'b1;
      rows[i].l0    = 8'hFF;
      rows[i].l1    = 8'hFF;
      rows[i].en    = 1'b0;
      rows[i].bits  = 16'h0000;
      rows[i].col   = 3'd0;
      rows[i].msb   = 1'b0;
      rows[i].ld    = 1'b0;
      rows[i].dn    = 1'b0;
      rows[i].bsy   = 1'b0;
      rows[i].rdy   = 1'b1;
    end
  endtask

  // Tile accepted in cycle c: columns in c+1..c+8, drain in c+9, done in c+10.
  // A later tile overwrites the drain row when it follows with no bubble.
  task automatic add_tile(input int c, input logic [7:0] a, input logic [7:0] b, input logic ld);
    rows[c].valid = 1'b1;
    rows[c].load  = ld;
    rows[c].l0    = a;
    rows[c].l1    = b;
    for (int k = 0; k < 8; k++) begin
      rows[c+1+k].en   = 1'b1;
      rows[c+1+k].bsy  = 1'b1;
      rows[c+1+k].bits = {14'b0, b[k], a[k]};
      rows[c+1+k].col  = 3'(k);
      rows[c+1+k].msb  = (k == 7);
      rows[c+1+k].rdy  = (k == 7);
    end
    if (ld) begin
      rows[c+2].ld = 1'b1;
    end
    rows[c+9].en   = 1'b1;
    rows[c+9].bsy  = 1'b1;
    rows[c+9].bits = 16'h0000;
    rows[c+9].col  = 3'd0;
    rows[c+9].msb  = 1'b0;
    rows[c+9].rdy  = 1'b1;
    rows[c+10].dn  = 1'b1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    w_valid = 1'b0;
    w_load  = 1'b0;
    w_in    = {(VL*DW){1'b0}};
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check(input string name, input int cyc, input logic [24:0] exp);
    logic [24:0] got;
    got = observed();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h (en,bits,col,msb,ld,done,busy,rdy)",
               name, cyc, got, exp);
    end
  endtask

  // Entered at the negedge inside cycle 0; one row per cycle.
  task automatic run_table(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      w_valid = rows[k].valid;
      w_load  = rows[k].load;
      w_in    = {(VL*DW){1'b0}};
      w_in[7:0]  = rows[k].l0;
      w_in[15:8] = rows[k].l1;
      check(name, k, {rows[k].en, rows[k].bits, rows[k].col, rows[k].msb,
                      rows[k].ld, rows[k].dn, rows[k].bsy, rows[k].rdy});
      @(negedge clk);
    end
    w_valid = 1'b0;
  endtask

  initial begin
    // Stall: valid low after reset, stray data and load must be ignored.
    do_reset();
    clear_rows();
    run_table("stall", 5);

    // Single tile with load.
    do_reset();
    clear_rows();
    add_tile(0, 8'hA5, 8'h80, 1'b1);
    run_table("single", 12);

    // Back-to-back: valid held high, second beat presented from cycle 1 on.
    do_reset();
    clear_rows();
    add_tile(0, 8'hA5, 8'h80, 1'b1);
    add_tile(8, 8'h3C, 8'h01, 1'b1);
    for (int i = 1; i < 8; i++) begin
      rows[i].valid = 1'b1;
      rows[i].load  = 1'b1;
      rows[i].l0    = 8'h3C;
      rows[i].l1    = 8'h01;
    end
    run_table("b2b", 20);

    // Tile without load.
    do_reset();
    clear_rows();
    add_tile(0, 8'hA5, 8'h80, 1'b0);
    run_table("noload", 12);

    // Second beat accepted during the drain cycle.
    do_reset();
    clear_rows();
    add_tile(0, 8'hA5, 8'h80, 1'b1);
    add_tile(9, 8'h5A, 8'hC3, 1'b0);
    run_table("drain_accept", 21);

    // Reset in cycle 4 of a tile.
    do_reset();
    w_valid = 1'b1;
    w_load  = 1'b1;
    w_in    = {(VL*DW){1'b0}};
    w_in[7:0]  = 8'hA5;
    w_in[15:8] = 8'h80;
    @(negedge clk);
    w_valid = 1'b0;
    check("rst_col0", 1, {1'b1, 16'h0001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rst_col3", 4, {1'b1, 16'h0000, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 5; k < 17; k++) begin
      check("rst_after", k, {1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
